dmem_store_buffer: RTL and testbench
====================================

DMEM_STORE_BUFFER -- requirements
Module: dmem_store_buffer

Interface
REQ-001 The block SHALL have one clock, clk; reset SHALL be asynchronous and active-low, port name reset.
REQ-002 Parameter DEPTH, default 4, number of buffered stores (power of two, 2..16).
REQ-003 clk  in  1  clock, all state updates on rising edge.
REQ-004 reset  in  1  asynchronous active-low reset.
REQ-005 MemWrite  in  1  processor store request, this cycle.
REQ-006 ALUResult1  in  32  processor byte address for load/store; bits[1:0] ignored.
REQ-007 WriteData  in  32  processor store data.
REQ-008 ReadData  out  32  processor load data, combinational.
REQ-009 Stall  out  1  store not accepted this cycle; processor holds the instruction.
REQ-010 Empty  out  1  buffer holds no entries.
REQ-011 Count  out  $clog2(DEPTH)+1  current occupancy.
REQ-012 mem_raddr  out  32  backing-memory read address = {ALUResult1[31:2],2'b00}.
REQ-013 mem_rdata  in  32  backing-memory combinational read data.
REQ-014 mem_wvalid  out  1  head entry offered to backing memory.
REQ-015 mem_wready  in  1  backing memory accepts head entry.
REQ-016 mem_waddr  out  32  head entry word address (bits[1:0]=0).
REQ-017 mem_wdata  out  32  head entry data.

Function
REQ-018 Storage SHALL be a FIFO of DEPTH entries {word address, data} with head/tail pointers wrapping modulo DEPTH.
REQ-019 Enqueue SHALL occur at the clock edge iff MemWrite=1 and Count<DEPTH; entry becomes visible the following cycle.
REQ-020 Stall SHALL equal MemWrite AND (Count==DEPTH), independent of mem_wready (no combinational path from mem_wready).
REQ-021 mem_wvalid SHALL equal (Count!=0); mem_waddr/mem_wdata SHALL be the head entry.
REQ-022 Dequeue SHALL occur at the clock edge iff mem_wvalid=1 and mem_wready=1; head SHALL stay stable while mem_wvalid=1 and mem_wready=0.
REQ-023 Simultaneous enqueue and dequeue SHALL leave Count unchanged and advance both pointers.
REQ-024 Drain order SHALL be strict enqueue order; no coalescing, no reordering.
REQ-025 ReadData SHALL return data of the youngest valid entry whose address matches mem_raddr, else mem_rdata.
REQ-026 A store and a read to the same address in the same cycle SHALL return pre-edge contents (the new store not forwarded).
REQ-027 An entry being dequeued this cycle SHALL still forward this cycle.
REQ-028 Empty SHALL equal (Count==0); Count SHALL never exceed DEPTH nor underflow.

Reset
REQ-029 While reset=0: Count=0, pointers=0, all entry valid bits=0, mem_wvalid=0, Empty=1, Stall=0 if MemWrite=0 else 0 (buffer empty).
REQ-030 Reset assertion mid-drain SHALL discard all pending entries immediately (asynchronously); ReadData SHALL then equal mem_rdata.
REQ-031 Entry address/data storage need not be reset.

Verification
REQ-032 Reset, mem_wready=0, store 0x10<-0xDEADBEEF -> next cycle Count=1, mem_wvalid=1, mem_waddr=0x10, mem_wdata=0xDEADBEEF; load 0x13 with mem_rdata=0 -> ReadData=0xDEADBEEF.
REQ-033 mem_wready=0, stores to 0x0,0x4,0x8,0xC then store 0x20 -> Count=4, Stall=1 on fifth, not enqueued; then mem_wready=1 -> mem_waddr 0x0,0x4,0x8,0xC on four consecutive cycles, Empty=1 after.
REQ-034 Stores 0x20<-1 then 0x20<-2, mem_wready=0, mem_rdata=0x55 -> load 0x20 returns 2; load 0x24 returns 0x55.
REQ-035 Count=2, mem_wready=1, store 0x40<-7 -> Count stays 2, head advances, 0x40 drains last.
REQ-036 Count=3, drive reset=0 between edges -> mem_wvalid=0 and Count=0 before next edge; ReadData=mem_rdata.
REQ-037 DEPTH=4, 12 stores with mem_wready toggling every cycle -> pointers wrap ≥2 times, drained sequence equals store sequence, no Stall when Count<4.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// Data-memory store buffer.
// Stores are queued in a small FIFO and drained to the backing memory
// with a valid/ready handshake. Loads see the youngest buffered store
// to the same word; otherwise they see the backing memory's read data.
module dmem_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWrite,
    input  logic [31:0]              ALUResult1,
    input  logic [31:0]              WriteData,
    output logic [31:0]              ReadData,
    output logic                     Stall,
    output logic                     Empty,
    output logic [$clog2(DEPTH):0]   Count,
    output logic [31:0]              mem_raddr,
    input  logic [31:0]              mem_rdata,
    output logic                     mem_wvalid,
    input  logic                     mem_wready,
    output logic [31:0]              mem_waddr,
    output logic [31:0]              mem_wdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [AW-1:0]    head_q;
    logic [AW-1:0]    tail_q;
    logic [CW-1:0]    count_q;
    logic [AW-1:0]    fwd_idx;
    logic             full;
    logic             enq;
    logic             deq;

    // Full/handshake decode; Stall depends only on occupancy, never on mem_wready.
    assign full       = (count_q == CW'(DEPTH));
    assign enq        = MemWrite && !full;
    assign deq        = (count_q != '0) && mem_wready;
    assign Stall      = MemWrite && full;
    assign Empty      = (count_q == '0);
    assign mem_wvalid = (count_q != '0);
    assign Count      = count_q;
    assign mem_raddr  = ALUResult1 & 32'hFFFF_FFFC;
    assign mem_waddr  = {addr_q[head_q], 2'b00};
    assign mem_wdata  = data_q[head_q];

    // Forwarding: walk entries oldest to youngest so the youngest match wins.
    always_comb begin
        ReadData = mem_rdata;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + AW'(i);
            if (valid_q[fwd_idx] && (addr_q[fwd_idx] == mem_raddr[31:2])) begin
                ReadData = data_q[fwd_idx];
            end
        end
    end

    // Pointer, occupancy and valid-bit bookkeeping; reset discards everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (deq) begin
                head_q          <= head_q + 1'b1;
                valid_q[head_q] <= 1'b0;
            end
            if (enq) begin
                tail_q          <= tail_q + 1'b1;
                valid_q[tail_q] <= 1'b1;
            end
            if (enq && !deq) begin
                count_q <= count_q + 1'b1;
            end else if (deq && !enq) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Entry payload storage; left unreset because valid bits gate every use.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= ALUResult1[31:2];
            data_q[tail_q] <= WriteData;
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer: a queue-based reference model
// predicts occupancy/forwarding, and a scoreboard checks the drain stream.
module tb_dmem_store_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] ALUResult1;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Empty;
    logic [2:0]  Count;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;

    int checks;
    int errors;

    entry_t model[$];
    entry_t sbq[$];

    dmem_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .MemWrite(MemWrite),
        .ALUResult1(ALUResult1),
        .WriteData(WriteData),
        .ReadData(ReadData),
        .Stall(Stall),
        .Empty(Empty),
        .Count(Count),
        .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata),
        .mem_wvalid(mem_wvalid),
        .mem_wready(mem_wready),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check combinational
    // outputs against the model, then advance the model for the next rising edge.
    task automatic applyStimulus(input logic mw, input logic [31:0] addr, input logic [31:0] wd,
                                 input logic wr, input logic [31:0] rd);
        logic [31:0] expRead;
        logic [31:0] waddr;
        entry_t      e;
        @(negedge clk);
        MemWrite   = mw;
        ALUResult1 = addr;
        WriteData  = wd;
        mem_wready = wr;
        mem_rdata  = rd;
        #1;
        waddr   = addr & 32'hFFFF_FFFC;
        expRead = rd;
        foreach (model[i]) begin
            if (model[i].addr == waddr) expRead = model[i].data;
        end
        checkOutput("Count", {29'd0, Count}, model.size());
        checkOutput("Empty", {31'd0, Empty}, {31'd0, model.size() == 0});
        checkOutput("Stall", {31'd0, Stall}, {31'd0, mw && (model.size() == DEPTH)});
        checkOutput("mem_wvalid", {31'd0, mem_wvalid}, {31'd0, model.size() != 0});
        checkOutput("mem_raddr", mem_raddr, waddr);
        checkOutput("ReadData", ReadData, expRead);
        if (model.size() != 0) begin
            checkOutput("head_addr", mem_waddr, model[0].addr);
            checkOutput("head_data", mem_wdata, model[0].data);
        end
        if (model.size() != 0 && wr) void'(model.pop_front());
        if (mw && (model.size() < DEPTH || (wr && model.size() == DEPTH - 1 + 0 && 1'b0))) begin
        end
    endtask

    // Model update kept separate so acceptance uses pre-edge occupancy.
    task automatic cycle(input logic mw, input logic [31:0] addr, input logic [31:0] wd,
                         input logic wr, input logic [31:0] rd);
        int     preSize;
        entry_t e;
        preSize = model.size();
        applyStimulus(mw, addr, wd, 1'b0, rd);
        mem_wready = wr;
        #0;
        if (preSize != 0 && wr) void'(model.pop_front());
        if (mw && preSize < DEPTH) begin
            e.addr = addr & 32'hFFFF_FFFC;
            e.data = wd;
            model.push_back(e);
            sbq.push_back(e);
        end
    endtask

    // Scoreboard monitor: every accepted drain handshake must match the oldest expected store.
    initial begin
        entry_t exp;
        forever begin
            @(negedge clk);
            #2;
            if (reset && mem_wvalid && mem_wready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL drain_unexpected got %h expected none", mem_waddr);
                end else begin
                    exp = sbq.pop_front();
                    checkOutput("drain_addr", mem_waddr, exp.addr);
                    checkOutput("drain_data", mem_wdata, exp.data);
                end
            end
        end
    end

    // Asynchronous reset asserted between edges with entries pending.
    task automatic midReset();
        @(negedge clk);
        MemWrite   = 1'b0;
        mem_wready = 1'b0;
        ALUResult1 = model.size() != 0 ? model[0].addr : 32'h0;
        mem_rdata  = 32'hA5A5_0F0F;
        #1;
        reset = 1'b0;
        #1;
        checkOutput("rst_Count", {29'd0, Count}, 32'd0);
        checkOutput("rst_wvalid", {31'd0, mem_wvalid}, 32'd0);
        checkOutput("rst_Empty", {31'd0, Empty}, 32'd1);
        checkOutput("rst_ReadData", ReadData, 32'hA5A5_0F0F);
        model.delete();
        sbq.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        MemWrite   = 1'b0;
        ALUResult1 = '0;
        WriteData  = '0;
        mem_rdata  = '0;
        mem_wready = 1'b0;

        // Reset state, including a store request held during reset.
        repeat (2) @(negedge clk);
        MemWrite = 1'b1;
        #1;
        checkOutput("reset_Count", {29'd0, Count}, 32'd0);
        checkOutput("reset_Empty", {31'd0, Empty}, 32'd1);
        checkOutput("reset_Stall", {31'd0, Stall}, 32'd0);
        checkOutput("reset_wvalid", {31'd0, mem_wvalid}, 32'd0);
        @(negedge clk);
        MemWrite = 1'b0;
        reset    = 1'b1;

        // Single store, then forwarded load to a sub-word address.
        cycle(1, 32'h10, 32'hDEADBEEF, 0, 0);
        cycle(0, 32'h13, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);

        // Fill to capacity, overflow store stalls, then drain in order.
        cycle(1, 32'h0, 32'h100, 0, 0);
        cycle(1, 32'h4, 32'h104, 0, 0);
        cycle(1, 32'h8, 32'h108, 0, 0);
        cycle(1, 32'hC, 32'h10C, 0, 0);
        cycle(1, 32'h20, 32'h120, 0, 0);
        repeat (4) cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);

        // Two stores to one word: youngest forwards; other words read memory.
        cycle(1, 32'h20, 32'd1, 0, 32'h55);
        cycle(1, 32'h20, 32'd2, 0, 32'h55);
        cycle(0, 32'h20, 0, 0, 32'h55);
        cycle(0, 32'h24, 0, 0, 32'h55);
        // Same-cycle store and load: the new store must not forward.
        cycle(1, 32'h20, 32'd3, 0, 32'h55);
        repeat (4) cycle(0, 32'h20, 0, 1, 32'h55);

        // Simultaneous enqueue and dequeue keeps occupancy.
        cycle(1, 32'h30, 32'd5, 0, 0);
        cycle(1, 32'h34, 32'd6, 0, 0);
        cycle(1, 32'h40, 32'd7, 1, 0);
        repeat (3) cycle(0, 32'h40, 0, 1, 0);

        // Reset with three entries pending.
        cycle(1, 32'h50, 32'd11, 0, 0);
        cycle(1, 32'h54, 32'd12, 0, 0);
        cycle(1, 32'h58, 32'd13, 0, 0);
        midReset();

        // Twelve stores with mem_wready toggling: pointers wrap repeatedly.
        for (int i = 0; i < 12; i++) begin
            cycle(1, 32'(i * 4), $urandom, 1'(i % 2), $urandom);
        end
        repeat (8) cycle(0, 0, 0, 1, 0);

        // Randomized traffic over a small address window to exercise forwarding.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
                  1'($urandom_range(0, 2) != 0), $urandom);
        end
        repeat (8) cycle(0, 0, 0, 1, 0);
        checkOutput("scoreboard_empty", sbq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
